sub_regbank: RTL and testbench



---
 rtl/sub_regbank.sv | 163 ++++++++++++++++
 tb/tb_sub_regbank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_regbank.sv
// Register bank with shadowed B registers, registered reads and an LAT-deep side-band pipe.
// Reads take 1 cycle; the write port stalls (o_wr_rdy=0) for the single COPY cycle of a commit.
module sub_regbank #(
  parameter int DW  = 8,
  parameter int NA  = 5,
  parameter int NB  = 3,
  parameter int NCH = 3,
  parameter int AW  = 5,
  parameter int LAT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_vld,
  output logic                       o_wr_rdy,
  input  logic [AW-1:0]              i_wr_addr,
  input  logic [DW-1:0]              i_wr_data,
  input  logic                       i_rd_vld,
  input  logic [AW-1:0]              i_rd_addr,
  output logic                       o_rd_vld,
  output logic [DW-1:0]              o_rd_data,
  input  logic                       i_commit,
  output logic [7:0]                 o_commit_cnt,
  input  logic                       i_err_clr,
  output logic                       o_err,
  output logic [DW-1:0]              o_reg_a [0:NA-1],
  output logic [0:NB-1][DW-1:0]      o_reg_b,
  input  logic                       i_sig_a,
  output logic                       o_sig_e,
  input  logic [1:0]                 i_sig_b,
  output logic [1:0]                 o_sig_f,
  input  logic [0:NCH-1][DW-1:0]     i_sig_c,
  output logic [0:NCH-1][DW-1:0]     o_sig_g,
  input  logic [DW-1:0]              i_sig_d [0:NCH-1],
  output logic [DW-1:0]              o_sig_h [0:NCH-1]
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_t;

  localparam logic [AW-1:0] ADDR_END = AW'(NA + NB);

  state_t          state_q, state_d;
  logic            copy_en;
  logic            wr_fire;
  logic            wr_oor;
  logic            rd_oor;
  logic            err_set;
  logic [DW-1:0]   rd_mux;
  logic [DW-1:0]   shadow_b [0:NB-1];

  logic                   sa_pipe [0:LAT-1];
  logic [1:0]             sb_pipe [0:LAT-1];
  logic [0:NCH-1][DW-1:0] sc_pipe [0:LAT-1];
  logic [DW-1:0]          sd_pipe [0:LAT-1][0:NCH-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    o_wr_rdy = 1'b0;
    copy_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_wr_rdy = 1'b1;
        if (i_commit) state_d = ST_COPY;
      end
      ST_COPY: begin
        copy_en = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_fire = i_wr_vld && o_wr_rdy;
  assign wr_oor  = (i_wr_addr >= ADDR_END);
  assign rd_oor  = (i_rd_addr >= ADDR_END);
  assign err_set = (wr_fire && wr_oor) || (i_rd_vld && rd_oor);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < NA; n++) o_reg_a[n] <= '0;
      for (int n = 0; n < NB; n++) begin
        shadow_b[n] <= '0;
        o_reg_b[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NA; n++)
        if (wr_fire && (i_wr_addr == AW'(n))) o_reg_a[n] <= i_wr_data;
      for (int n = 0; n < NB; n++)
        if (wr_fire && (i_wr_addr == AW'(NA + n))) shadow_b[n] <= i_wr_data;
      // Writes are stalled during COPY, so the shadow is stable while it is copied.
      if (copy_en)
        for (int n = 0; n < NB; n++) o_reg_b[n] <= shadow_b[n];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)        o_commit_cnt <= '0;
    else if (copy_en) o_commit_cnt <= o_commit_cnt + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          o_err <= 1'b0;
    else if (err_set)   o_err <= 1'b1;
    else if (i_err_clr) o_err <= 1'b0;
  end

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NA; n++)
      if (i_rd_addr == AW'(n)) rd_mux = o_reg_a[n];
    for (int n = 0; n < NB; n++)
      if (i_rd_addr == AW'(NA + n)) rd_mux = shadow_b[n];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_vld  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_rd_vld <= i_rd_vld;
      if (i_rd_vld) o_rd_data <= rd_mux;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < LAT; s++) begin
        sa_pipe[s] <= 1'b0;
        sb_pipe[s] <= '0;
        sc_pipe[s] <= '0;
        for (int k = 0; k < NCH; k++) sd_pipe[s][k] <= '0;
      end
    end else begin
      sa_pipe[0] <= i_sig_a;
      sb_pipe[0] <= i_sig_b;
      sc_pipe[0] <= i_sig_c;
      for (int k = 0; k < NCH; k++) sd_pipe[0][k] <= i_sig_d[k];
      for (int s = 1; s < LAT; s++) begin
        sa_pipe[s] <= sa_pipe[s-1];
        sb_pipe[s] <= sb_pipe[s-1];
        sc_pipe[s] <= sc_pipe[s-1];
        for (int k = 0; k < NCH; k++) sd_pipe[s][k] <= sd_pipe[s-1][k];
      end
    end
  end

  assign o_sig_e = sa_pipe[LAT-1];
  assign o_sig_f = sb_pipe[LAT-1];
  assign o_sig_g = sc_pipe[LAT-1];

  always_comb begin
    for (int k = 0; k < NCH; k++) o_sig_h[k] = sd_pipe[LAT-1][k];
  end

endmodule

// File: tb/tb_sub_regbank.sv
// Scoreboard bench for sub_regbank: an address-map model predicts register, read and pipe outputs.
module tb_sub_regbank;

  localparam int DW  = 8;
  localparam int NA  = 5;
  localparam int NB  = 3;
  localparam int NCH = 3;
  localparam int AW  = 5;
  localparam int LAT = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_vld, wr_rdy;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   rd_vld;
  logic [AW-1:0]          rd_addr;
  logic                   rd_out_vld;
  logic [DW-1:0]          rd_data;
  logic                   commit;
  logic [7:0]             commit_cnt;
  logic                   err_clr, err;
  logic [DW-1:0]          reg_a [0:NA-1];
  logic [0:NB-1][DW-1:0]  reg_b;
  logic                   sig_a, sig_e;
  logic [1:0]             sig_b, sig_f;
  logic [0:NCH-1][DW-1:0] sig_c, sig_g;
  logic [DW-1:0]          sig_d [0:NCH-1];
  logic [DW-1:0]          sig_h [0:NCH-1];

  sub_regbank #(.DW(DW), .NA(NA), .NB(NB), .NCH(NCH), .AW(AW), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_vld(wr_vld), .o_wr_rdy(wr_rdy), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_vld(rd_vld), .i_rd_addr(rd_addr), .o_rd_vld(rd_out_vld), .o_rd_data(rd_data),
    .i_commit(commit), .o_commit_cnt(commit_cnt),
    .i_err_clr(err_clr), .o_err(err),
    .o_reg_a(reg_a), .o_reg_b(reg_b),
    .i_sig_a(sig_a), .o_sig_e(sig_e),
    .i_sig_b(sig_b), .o_sig_f(sig_f),
    .i_sig_c(sig_c), .o_sig_g(sig_g),
    .i_sig_d(sig_d), .o_sig_h(sig_h)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct packed {
    logic                   a;
    logic [1:0]             b;
    logic [0:NCH-1][DW-1:0] c;
    logic [0:NCH-1][DW-1:0] d;
  } pt_t;

  // Reference model: plain arrays indexed by address, one busy flag for the copy cycle.
  logic [DW-1:0] m_a  [NA];
  logic [DW-1:0] m_sb [NB];
  logic [DW-1:0] m_lb [NB];
  logic          m_err, m_busy;
  logic [7:0]    m_cnt;
  bit            m_ok = 1'b0;
  logic [DW-1:0] rd_q [$];
  pt_t           hist [$];

  always @(posedge clk) begin
    pt_t  smp;
    logic wr_acc;
    logic bad;
    int   wa, ra;
    if (rst) begin
      for (int n = 0; n < NA; n++) m_a[n] = '0;
      for (int n = 0; n < NB; n++) begin m_sb[n] = '0; m_lb[n] = '0; end
      m_err = 1'b0; m_busy = 1'b0; m_cnt = '0;
      rd_q.delete();
      hist.delete();
      for (int s = 0; s < LAT; s++) hist.push_back('0);
      m_ok = 1'b1;
    end else if (m_ok) begin
      wa = int'(wr_addr);
      ra = int'(rd_addr);
      bad = 1'b0;
      wr_acc = wr_vld && !m_busy;
      if (rd_vld) begin
        if (ra < NA)           rd_q.push_back(m_a[ra]);
        else if (ra < NA + NB) rd_q.push_back(m_sb[ra-NA]);
        else begin             rd_q.push_back('0); bad = 1'b1; end
      end
      if (m_busy) begin
        for (int n = 0; n < NB; n++) m_lb[n] = m_sb[n];
        m_cnt = m_cnt + 8'd1;
        m_busy = 1'b0;
      end else if (commit) begin
        m_busy = 1'b1;
      end
      if (wr_acc) begin
        if (wa < NA)           m_a[wa] = wr_data;
        else if (wa < NA + NB) m_sb[wa-NA] = wr_data;
        else                   bad = 1'b1;
      end
      if (bad)          m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      smp.a = sig_a;
      smp.b = sig_b;
      smp.c = sig_c;
      for (int k = 0; k < NCH; k++) smp.d[k] = sig_d[k];
      hist.push_back(smp);
      if (hist.size() > LAT) void'(hist.pop_front());
    end
  end

  // Monitor: compares every visible output against the model away from the active edge.
  always @(negedge clk) begin
    pt_t           e;
    logic [DW-1:0] ex;
    if (m_ok) begin
      chk("wr_rdy", 32'(wr_rdy), 32'(!m_busy));
      chk("commit_cnt", 32'(commit_cnt), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      for (int n = 0; n < NA; n++) chk($sformatf("reg_a[%0d]", n), 32'(reg_a[n]), 32'(m_a[n]));
      for (int n = 0; n < NB; n++) chk($sformatf("reg_b[%0d]", n), 32'(reg_b[n]), 32'(m_lb[n]));
      chk("rd_vld", 32'(rd_out_vld), 32'(rd_q.size() != 0));
      if (rd_q.size() != 0) begin
        ex = rd_q.pop_front();
        if (rd_out_vld) chk("rd_data", 32'(rd_data), 32'(ex));
      end
      if (hist.size() == LAT) begin
        e = hist[0];
        chk("sig_e", 32'(sig_e), 32'(e.a));
        chk("sig_f", 32'(sig_f), 32'(e.b));
        for (int k = 0; k < NCH; k++) begin
          chk($sformatf("sig_g[%0d]", k), 32'(sig_g[k]), 32'(e.c[k]));
          chk($sformatf("sig_h[%0d]", k), 32'(sig_h[k]), 32'(e.d[k]));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_idle();
    wr_vld = 1'b0; wr_addr = '0; wr_data = '0;
    rd_vld = 1'b0; rd_addr = '0;
    commit = 1'b0; err_clr = 1'b0;
    sig_a = 1'b0; sig_b = '0; sig_c = '0;
    for (int k = 0; k < NCH; k++) sig_d[k] = '0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("rst_cnt", 32'(commit_cnt), 32'd0);
    rst = 1'b0;

    wr_vld = 1'b1; wr_addr = 5'd2; wr_data = 8'h5A;
    tick();
    wr_vld = 1'b0;
    chk("a2_write", 32'(reg_a[2]), 32'h5A);
    rd_vld = 1'b1; rd_addr = 5'd2;
    tick();
    rd_vld = 1'b0;
    chk("a2_read_vld", 32'(rd_out_vld), 32'd1);
    chk("a2_read_data", 32'(rd_data), 32'h5A);

    wr_vld = 1'b1; wr_addr = 5'd6; wr_data = 8'h33;
    tick();
    wr_vld = 1'b0;
    chk("b1_shadow_hidden", 32'(reg_b[1]), 32'h00);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("copy_wr_rdy", 32'(wr_rdy), 32'd0);
    tick();
    chk("post_copy_rdy", 32'(wr_rdy), 32'd1);
    chk("b1_live", 32'(reg_b[1]), 32'h33);
    chk("cnt_one", 32'(commit_cnt), 32'd1);

    wr_vld = 1'b1; wr_addr = 5'd7; wr_data = 8'h99; commit = 1'b1;
    tick();
    wr_vld = 1'b0;
    tick();
    commit = 1'b0;
    chk("b2_same_cycle", 32'(reg_b[2]), 32'h99);
    chk("cnt_ignore_busy", 32'(commit_cnt), 32'd2);
    for (int i = 0; i < 254; i++) begin
      commit = 1'b1; tick();
      commit = 1'b0; tick();
    end
    chk("cnt_wrap", 32'(commit_cnt), 32'd0);

    wr_vld = 1'b1; wr_addr = 5'd9; wr_data = 8'h77;
    rd_vld = 1'b1; rd_addr = 5'd31;
    tick();
    wr_vld = 1'b0; rd_vld = 1'b0;
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_rd_data", 32'(rd_data), 32'd0);
    err_clr = 1'b1;
    tick();
    chk("err_clr", 32'(err), 32'd0);
    rd_vld = 1'b1; rd_addr = 5'd20;
    tick();
    err_clr = 1'b0; rd_vld = 1'b0;
    chk("err_set_wins", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    sig_c[0] = 8'h01; sig_c[1] = 8'h02; sig_c[2] = 8'h03;
    sig_d[0] = 8'h0A; sig_d[1] = 8'h0B; sig_d[2] = 8'h0C;
    tick();
    sig_c = '0;
    for (int k = 0; k < NCH; k++) sig_d[k] = '0;
    repeat (LAT - 1) tick();
    chk("pipe_g0", 32'(sig_g[0]), 32'h01);
    chk("pipe_g2", 32'(sig_g[2]), 32'h03);
    chk("pipe_h0", 32'(sig_h[0]), 32'h0A);
    chk("pipe_h2", 32'(sig_h[2]), 32'h0C);

    wr_vld = 1'b1; wr_addr = 5'd5; wr_data = 8'hFF; commit = 1'b1;
    tick();
    wr_vld = 1'b0; commit = 1'b0;
    chk("pre_abort_busy", 32'(wr_rdy), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_b0", 32'(reg_b[0]), 32'd0);
    chk("abort_rdy", 32'(wr_rdy), 32'd1);
    tick();
    chk("abort_b0_stays", 32'(reg_b[0]), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      wr_vld  = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(8, 31)) : AW'($urandom_range(0, 7));
      wr_data = DW'($urandom);
      rd_vld  = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(8, 31)) : AW'($urandom_range(0, 7));
      commit  = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      sig_a   = 1'($urandom);
      sig_b   = 2'($urandom);
      for (int k = 0; k < NCH; k++) begin
        sig_c[k] = DW'($urandom);
        sig_d[k] = DW'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    set_idle();
    repeat (LAT + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
